// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: load funct3 codes, FSM state type, default width.
package wb_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Combinational load-data alignment and sign/zero extension.
// Unknown funct3 codes raise illegal; value is then don't-care (driven as zero).
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] value,
  output logic            illegal
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = rdata[{off, 3'b000} +: 8];
    half_v  = rdata[{off[1], 4'b0000} +: 16];
    value   = '0;
    illegal = 1'b0;
    case (funct3)
      F3_LB:   value = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:   value = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU:  value = {{(XLEN-16){1'b0}}, half_v};
      F3_LW:   value = rdata;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: registers ALU results and load data into decode's register-file write port.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
//
// state     | meaning
// IDLE      | ready for a new instruction; ALU ops retire here
// LOAD_WAIT | load accepted, waiting for dmem_rvalid_in or timeout
module writeback
  import wb_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16,
  parameter int XLEN         = XLEN_DEFAULT
) (
  input  logic            req,
  input  logic            reset,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [4:0]      rd_in,
  input  logic            rd_write_in,
  input  logic            mem_read_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic            dmem_rvalid_in,
  input  logic [XLEN-1:0] dmem_rdata_in,
  output logic [4:0]      rd_out,
  output logic            rd_write_out,
  output logic [XLEN-1:0] rd_value_out,
  output logic            err_out
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     instret_out
`endif
);

  localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_off_q, ld_off_d;
  logic            ld_wr_q, ld_wr_d;
  logic [4:0]      rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [XLEN-1:0] val_q, val_d;
  logic            err_q, err_d;
  logic            complete;

  logic [XLEN-1:0] align_value;
  logic            align_illegal;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3  (ld_f3_q),
    .off     (ld_off_q),
    .rdata   (dmem_rdata_in),
    .value   (align_value),
    .illegal (align_illegal)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_rd_d  = ld_rd_q;
    ld_f3_d  = ld_f3_q;
    ld_off_d = ld_off_q;
    ld_wr_d  = ld_wr_q;
    rd_d     = rd_q;
    val_d    = val_q;
    wr_d     = 1'b0;
    err_d    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (!mem_read_in) begin
            rd_d     = rd_in;
            val_d    = alu_result_in;
            wr_d     = rd_write_in && (rd_in != 5'd0);
            complete = 1'b1;
          end else begin
            ld_rd_d  = rd_in;
            ld_f3_d  = funct3_in;
            ld_off_d = alu_result_in[1:0];
            ld_wr_d  = rd_write_in;
            cnt_d    = '0;
            state_d  = LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        if (dmem_rvalid_in) begin
          state_d = IDLE;
          if (align_illegal) begin
            err_d = 1'b1;
          end else begin
            rd_d     = ld_rd_q;
            val_d    = align_value;
            wr_d     = ld_wr_q && (ld_rd_q != 5'd0);
            complete = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge req or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ld_rd_q  <= '0;
      ld_f3_q  <= '0;
      ld_off_q <= '0;
      ld_wr_q  <= 1'b0;
      rd_q     <= '0;
      wr_q     <= 1'b0;
      val_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ld_rd_q  <= ld_rd_d;
      ld_f3_q  <= ld_f3_d;
      ld_off_q <= ld_off_d;
      ld_wr_q  <= ld_wr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      val_q    <= val_d;
      err_q    <= err_d;
    end
  end

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  always_comb begin
    instret_d = complete ? instret_q + 64'd1 : instret_q;
  end

  always_ff @(posedge req or posedge reset) begin
    if (reset) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  assign instret_out = instret_q;
`else
  logic unused_complete;
  assign unused_complete = complete;
`endif

  assign ready_out    = (state_q == IDLE);
  assign rd_out       = rd_q;
  assign rd_write_out = wr_q;
  assign rd_value_out = val_q;
  assign err_out      = err_q;

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for writeback; define WB_INSTRET_EN to also check instret_out.
module tb_writeback;

  localparam int XLEN = 32;
  localparam int LOAD_TIMEOUT = 16;

  logic            req = 1'b0;
  logic            reset;
  logic            valid_in;
  logic            ready_out;
  logic [4:0]      rd_in;
  logic            rd_write_in;
  logic            mem_read_in;
  logic [2:0]      funct3_in;
  logic [XLEN-1:0] alu_result_in;
  logic            dmem_rvalid_in;
  logic [XLEN-1:0] dmem_rdata_in;
  logic [4:0]      rd_out;
  logic            rd_write_out;
  logic [XLEN-1:0] rd_value_out;
  logic            err_out;
`ifdef WB_INSTRET_EN
  logic [63:0]     instret_out;
`endif

  int checks = 0;
  int passes = 0;

  writeback #(.LOAD_TIMEOUT(LOAD_TIMEOUT), .XLEN(XLEN)) dut (
    .req            (req),
    .reset          (reset),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .rd_in          (rd_in),
    .rd_write_in    (rd_write_in),
    .mem_read_in    (mem_read_in),
    .funct3_in      (funct3_in),
    .alu_result_in  (alu_result_in),
    .dmem_rvalid_in (dmem_rvalid_in),
    .dmem_rdata_in  (dmem_rdata_in),
    .rd_out         (rd_out),
    .rd_write_out   (rd_write_out),
    .rd_value_out   (rd_value_out),
    .err_out        (err_out)
`ifdef WB_INSTRET_EN
    ,
    .instret_out    (instret_out)
`endif
  );

  always #5 req = ~req;

  task automatic step();
    @(posedge req);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in       = 1'b0;
    rd_in          = 5'd0;
    rd_write_in    = 1'b0;
    mem_read_in    = 1'b0;
    funct3_in      = 3'b000;
    alu_result_in  = '0;
    dmem_rvalid_in = 1'b0;
    dmem_rdata_in  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({ready_out, rd_out, rd_write_out, rd_value_out, err_out} !== {1'b1, 5'd0, 1'b0, 32'd0, 1'b0})
      $display("FAIL reset_state: got ready=%0b rd=%0d wr=%0b val=%h err=%0b, want 1 0 0 0 0",
               ready_out, rd_out, rd_write_out, rd_value_out, err_out);
    else passes++;
`ifdef WB_INSTRET_EN
    checks++;
    if (instret_out !== 64'd0) $display("FAIL reset_instret: got %0d want 0", instret_out);
    else passes++;
`endif
    reset = 1'b0;
    step();
  endtask

  task automatic test_alu();
    valid_in = 1'b1; rd_in = 5'd5; rd_write_in = 1'b1; mem_read_in = 1'b0;
    alu_result_in = 32'h0000_1234;
    step();
    valid_in = 1'b0;
    checks++;
    if ({rd_out, rd_write_out, rd_value_out, ready_out} !== {5'd5, 1'b1, 32'h1234, 1'b1})
      $display("FAIL alu_write: got rd=%0d wr=%0b val=%h ready=%0b, want 5 1 00001234 1",
               rd_out, rd_write_out, rd_value_out, ready_out);
    else passes++;
    step();
    checks++;
    if (rd_write_out !== 1'b0) $display("FAIL alu_pulse: got wr=%0b want 0", rd_write_out);
    else passes++;
  endtask

  task automatic test_back_to_back();
    valid_in = 1'b1; rd_in = 5'd0; rd_write_in = 1'b1; mem_read_in = 1'b0;
    alu_result_in = 32'h0000_AAAA;
    step();
    rd_in = 5'd7; alu_result_in = 32'h0000_0077;
    checks++;
    if ({rd_out, rd_write_out, rd_value_out} !== {5'd0, 1'b0, 32'hAAAA})
      $display("FAIL b2b_rd0: got rd=%0d wr=%0b val=%h, want 0 0 0000aaaa",
               rd_out, rd_write_out, rd_value_out);
    else passes++;
    step();
    valid_in = 1'b0;
    checks++;
    if ({rd_out, rd_write_out, rd_value_out} !== {5'd7, 1'b1, 32'h77})
      $display("FAIL b2b_rd7: got rd=%0d wr=%0b val=%h, want 7 1 00000077",
               rd_out, rd_write_out, rd_value_out);
    else passes++;
    step();
  endtask

  // Accepts a load, raises rvalid on the delay-th wait cycle, checks the registered result.
  task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input int delay,
                         input logic [31:0] exp_val, input logic exp_err);
    logic ready_ok;
    ready_ok = 1'b1;
    valid_in = 1'b1; mem_read_in = 1'b1; rd_in = 5'd9; rd_write_in = 1'b1;
    funct3_in = f3; alu_result_in = addr;
    step();
    valid_in = 1'b0; mem_read_in = 1'b0;
    for (int i = 0; i < delay; i++) begin
      if (ready_out !== 1'b0 || rd_write_out !== 1'b0 || err_out !== 1'b0) ready_ok = 1'b0;
      if (i == delay - 1) begin
        dmem_rvalid_in = 1'b1;
        dmem_rdata_in  = rdata;
      end
      step();
    end
    dmem_rvalid_in = 1'b0;
    checks++;
    if (ready_ok !== 1'b1) $display("FAIL %s_wait: ready/wr/err not low during wait", name);
    else passes++;
    checks++;
    if (exp_err) begin
      if ({rd_write_out, err_out} !== 2'b01)
        $display("FAIL %s_err: got wr=%0b err=%0b, want 0 1", name, rd_write_out, err_out);
      else passes++;
    end else begin
      if ({rd_out, rd_write_out, rd_value_out, err_out} !== {5'd9, 1'b1, exp_val, 1'b0})
        $display("FAIL %s_value: got rd=%0d wr=%0b val=%h err=%0b, want 9 1 %h 0",
                 name, rd_out, rd_write_out, rd_value_out, err_out, exp_val);
      else passes++;
    end
    step();
    checks++;
    if ({ready_out, rd_write_out, err_out} !== 3'b100)
      $display("FAIL %s_after: got ready=%0b wr=%0b err=%0b, want 1 0 0",
               name, ready_out, rd_write_out, err_out);
    else passes++;
  endtask

  task automatic test_loads();
    do_load("lb",  3'b000, 32'h0000_1003, 32'h80FF_0000, 3, 32'hFFFF_FF80, 1'b0);
    do_load("lbu", 3'b100, 32'h0000_1003, 32'h80FF_0000, 3, 32'h0000_0080, 1'b0);
    do_load("lh",  3'b001, 32'h0000_2002, 32'h8001_1234, 1, 32'hFFFF_8001, 1'b0);
    do_load("lhu", 3'b101, 32'h0000_2002, 32'h8001_1234, 2, 32'h0000_8001, 1'b0);
    do_load("lw",  3'b010, 32'h0000_2000, 32'h8001_1234, 1, 32'h8001_1234, 1'b0);
    do_load("lb1", 3'b000, 32'h0000_0001, 32'h0000_7F00, 1, 32'h0000_007F, 1'b0);
    do_load("ill", 3'b011, 32'h0000_0000, 32'h1234_5678, 2, 32'h0, 1'b1);
  endtask

  task automatic test_timeout();
    logic [31:0] val_before;
    valid_in = 1'b1; mem_read_in = 1'b1; rd_in = 5'd3; rd_write_in = 1'b1;
    funct3_in = 3'b010; alu_result_in = 32'h0000_0040;
    step();
    valid_in = 1'b0; mem_read_in = 1'b0;
    val_before = rd_value_out;
    for (int i = 0; i < LOAD_TIMEOUT - 1; i++) step();
    checks++;
    if ({ready_out, err_out} !== 2'b00)
      $display("FAIL timeout_edge: got ready=%0b err=%0b after %0d wait cycles, want 0 0",
               ready_out, err_out, LOAD_TIMEOUT - 1);
    else passes++;
    step();
    checks++;
    if ({err_out, rd_write_out, ready_out} !== 3'b101)
      $display("FAIL timeout_err: got err=%0b wr=%0b ready=%0b, want 1 0 1",
               err_out, rd_write_out, ready_out);
    else passes++;
    dmem_rvalid_in = 1'b1; dmem_rdata_in = 32'hDEAD_BEEF;
    step();
    dmem_rvalid_in = 1'b0;
    checks++;
    if ({err_out, rd_write_out, rd_value_out} !== {1'b0, 1'b0, val_before})
      $display("FAIL late_rvalid: got err=%0b wr=%0b val=%h, want 0 0 %h",
               err_out, rd_write_out, rd_value_out, val_before);
    else passes++;
  endtask

  task automatic test_reset_in_wait();
    valid_in = 1'b1; mem_read_in = 1'b1; rd_in = 5'd4; rd_write_in = 1'b1;
    funct3_in = 3'b010; alu_result_in = 32'h0000_0080;
    step();
    valid_in = 1'b0; mem_read_in = 1'b0;
    step();
    reset = 1'b1;
    #1;
    checks++;
    if ({ready_out, rd_out, rd_write_out, rd_value_out, err_out} !== {1'b1, 5'd0, 1'b0, 32'd0, 1'b0})
      $display("FAIL reset_wait_async: got ready=%0b rd=%0d wr=%0b val=%h err=%0b, want 1 0 0 0 0",
               ready_out, rd_out, rd_write_out, rd_value_out, err_out);
    else passes++;
    step();
    reset = 1'b0;
    dmem_rvalid_in = 1'b1; dmem_rdata_in = 32'hCAFE_F00D;
    step();
    dmem_rvalid_in = 1'b0;
    checks++;
    if ({rd_write_out, rd_value_out, err_out, ready_out} !== {1'b0, 32'd0, 1'b0, 1'b1})
      $display("FAIL reset_wait_drop: got wr=%0b val=%h err=%0b ready=%0b, want 0 0 0 1",
               rd_write_out, rd_value_out, err_out, ready_out);
    else passes++;
`ifdef WB_INSTRET_EN
    checks++;
    if (instret_out !== 64'd0) $display("FAIL instret_after_reset: got %0d want 0", instret_out);
    else passes++;
`endif
  endtask

`ifdef WB_INSTRET_EN
  task automatic test_instret();
    valid_in = 1'b1; mem_read_in = 1'b0; rd_write_in = 1'b1;
    rd_in = 5'd1; alu_result_in = 32'h1;
    step();
    rd_in = 5'd0;
    step();
    rd_in = 5'd2; rd_write_in = 1'b0;
    step();
    valid_in = 1'b0;
    step();
    checks++;
    if (instret_out !== 64'd3) $display("FAIL instret_count: got %0d want 3", instret_out);
    else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_loads();
    test_timeout();
    test_reset_in_wait();
`ifdef WB_INSTRET_EN
    test_instret();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/writeback.md
Name: writeback

Overview:
- Final pipeline stage.
- Takes the executed instruction (ALU result or load request) and waits for the data-memory response on loads.
- Aligns and sign/zero-extends load data.
- Drives the register-file write port of decode (rd / rd_write / rd_value) with one registered write pulse per retired instruction.
- Is the write-side end of the register interface that decode reads.

Parameters:
- LOAD_TIMEOUT, 16: max cycles waiting for dmem_rvalid_in before a load is aborted. Must be ≥ 1.
- XLEN, 32: data width.

Ports:
- req  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  instruction present from execute stage
- ready_out  out  1  writeback can accept an instruction this cycle
- rd_in  in  5  destination register
- rd_write_in  in  1  instruction writes rd
- mem_read_in  in  1  instruction is a load
- funct3_in  in  3  load width/extension code
- alu_result_in  in  XLEN  ALU result; for loads, the byte address
- dmem_rvalid_in  in  1  load data valid
- dmem_rdata_in  in  XLEN  raw aligned word from data memory
- rd_out  out  5  to decode rd_in
- rd_write_out  out  1  to decode rd_write_in; one-cycle pulse
- rd_value_out  out  XLEN  to decode rd_value_in
- err_out  out  1  one-cycle pulse on load timeout or illegal funct3
- instret_out  out  64  retired-instruction count (only with WB_INSTRET_EN)

Behaviour:
- Clock and reset: one clock `req`. `reset` is asynchronous and active-high.
- Reset values: state=IDLE, ready_out=1, rd_out=0, rd_write_out=0, rd_value_out=0, err_out=0, instret_out=0, timeout counter=0.
- FSM states: IDLE, LOAD_WAIT.
- IDLE:
  - ready_out=1.
  - Accept when valid_in=1.
  - If mem_read_in=0: next cycle rd_out=rd_in, rd_value_out=alu_result_in, rd_write_out=rd_write_in && (rd_in!=0). Stay in IDLE. Throughput is 1 per cycle; latency is 1 cycle.
  - If mem_read_in=1: latch rd_in, funct3_in, alu_result_in[1:0] and rd_write_in. Go to LOAD_WAIT. Clear the counter.
- LOAD_WAIT:
  - ready_out=0. valid_in is ignored; upstream must hold.
  - dmem_rvalid_in=1: next cycle rd_value_out=extended data and rd_write_out=latched rd_write && rd!=0. Return to IDLE.
  - Otherwise the counter increments. When counter==LOAD_TIMEOUT-1 and rvalid is still 0: next cycle err_out=1, no write, return to IDLE.
- dmem_rvalid_in in IDLE is ignored; there is no response buffering.
- rvalid on the cycle the load is accepted is not sampled. The earliest response is the cycle after acceptance.
- Load extension (off = latched address bits [1:0]):
  - 000 LB: byte off, sign-extended.
  - 100 LBU: byte off, zero-extended.
  - 001 LH: half off[1], sign-extended.
  - 101 LHU: half off[1], zero-extended.
  - 010 LW: full word; off ignored (misalignment out of scope).
  - Any other code: no write, err_out pulse, on the same cycle the write would occur.
- rd_write_out is never 1 for rd=0. rd_out and rd_value_out still update.
- rd_write_out and err_out are single-cycle pulses, deasserted on the following cycle unless a new event occurs.
- Reset in LOAD_WAIT: the pending load is dropped, state returns to IDLE, and no write or err is issued.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined: instret_out port exists. A 64-bit counter increments by 1 on every cycle rd_write_out is asserted, and also for accepted non-writing instructions (rd_write_in=0 or rd=0) when they complete. It does not increment on err. It wraps at 2^64-1 to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package wb_pkg:
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - wb_state_t enum {IDLE, LOAD_WAIT}.
  - XLEN default.
- Sub-module load_align: purely combinational. Inputs: funct3, off[1:0], rdata. Outputs: value and an illegal flag.
- writeback holds the FSM, counter, and output registers.

Test Plan:
- ALU op: valid_in=1, rd=5, rd_write_in=1, alu_result=0x0000_1234 → next cycle rd_out=5, rd_value_out=0x1234, rd_write_out=1 for one cycle; ready_out stays 1.
- Back-to-back ALU ops to rd=0 then rd=7 → first gives rd_write_out=0, second gives a write of rd=7 on consecutive cycles.
- LB at addr ...03, rdata=0x80FF_0000, rvalid 3 cycles later:
  - ready_out=0 for 3 cycles.
  - Then rd_value_out=0xFFFF_FF80, rd_write_out=1.
  - The same case with LBU gives 0x0000_0080.
- LH at offset 2, rdata=0x8001_1234 → 0xFFFF_8001. LHU → 0x0000_8001. LW → 0x8001_1234.
- Load with no rvalid for LOAD_TIMEOUT=16 cycles → err_out pulses once, no write, ready_out=1 the next cycle. A late rvalid is ignored.
- Load accepted, reset asserted in LOAD_WAIT, rvalid arriving after reset release → outputs at reset values, no write. (WB_INSTRET_EN) instret_out stays 0 after reset and counts 3 after three completed ALU ops.
